// File: rtl/idix_issue_buffer.sv
// ID/IX issue buffer: 2-entry skid buffer (main + skid) between decode and execute, with flush.
// Optional performance counters are enabled with IDIX_PERF_CNT_EN.
module idix_issue_buffer #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 5,
  parameter int UOP_W  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] rs_id_p1,
  input  logic [DATA_W-1:0] rt_id_p1,
  input  logic [OPC_W-1:0]  opcode_id_p1,
  input  logic [UOP_W-1:0]  uop_cnt_id_p1,
  input  logic              execute_valid_id_p1,
  input  logic              ldst_valid_id_p1,
  input  logic              jmp_id_p1,
  input  logic              branch_id_p1,
  input  logic [DATA_W-1:0] pc_id_p1,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              idix_valid,
  output logic [DATA_W-1:0] rs_p1,
  output logic [DATA_W-1:0] rt_p1,
  output logic [OPC_W-1:0]  opcode_idix_p1,
  output logic [UOP_W-1:0]  uop_cnt_idix_p1,
  output logic [DATA_W-1:0] pc_p1,
  output logic              execute_valid_idix_p1,
  output logic              ldst_valid_idix_p1,
  output logic              jmp_idix_p1,
  output logic              branch_idix_p1,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [OPC_W-1:0]  opcode;
    logic [UOP_W-1:0]  uop;
    logic [DATA_W-1:0] pc;
    logic              exe;
    logic              ldst;
    logic              jmp;
    logic              br;
  } entry_t;

  entry_t in_e, main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   acc, pop;

  assign in_e = '{rs: rs_id_p1, rt: rt_id_p1, opcode: opcode_id_p1, uop: uop_cnt_id_p1,
                  pc: pc_id_p1, exe: execute_valid_id_p1, ldst: ldst_valid_id_p1,
                  jmp: jmp_id_p1, br: branch_id_p1};

  assign id_ready = ~skid_valid;
  assign acc      = id_valid & id_ready;
  assign pop      = main_valid & ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      // Data registers are left as-is; only occupancy is killed.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (acc) begin
        main_q     <= in_e;
        main_valid <= 1'b1;
      end
    end else if (pop) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (acc) begin
        main_q <= in_e;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_q     <= in_e;
      skid_valid <= 1'b1;
    end
  end

  assign idix_valid            = main_valid;
  assign rs_p1                 = main_q.rs;
  assign rt_p1                 = main_q.rt;
  assign opcode_idix_p1        = main_q.opcode;
  assign uop_cnt_idix_p1       = main_q.uop;
  assign pc_p1                 = main_q.pc;
  // Flags are gated so an empty head looks like a bubble downstream.
  assign execute_valid_idix_p1 = main_valid & main_q.exe;
  assign ldst_valid_idix_p1    = main_valid & main_q.ldst;
  assign jmp_idix_p1           = main_valid & main_q.jmp;
  assign branch_idix_p1        = main_valid & main_q.br;

`ifdef IDIX_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_valid && !ex_ready && !flush && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (flush && (main_valid || skid_valid) && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0;
  assign flush_cnt = 16'h0;
`endif

endmodule
